// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl_pkg
//  Description : Shared register map, widths and helpers for the interrupt
//                controller and its priority encoder.
//  Revision    : 1.0  initial release
// ============================================================================
package irq_ctrl_pkg;

    localparam int IRQ_MAX       = 16;
    localparam int IRQ_ID_W      = 4;
    localparam int IRQ_CUR_VALID = 15;

    localparam logic [2:0] IRQ_ADDR_PENDING = 3'd0;
    localparam logic [2:0] IRQ_ADDR_MASK    = 3'd1;
    localparam logic [2:0] IRQ_ADDR_EDGE    = 3'd2;
    localparam logic [2:0] IRQ_ADDR_CURRENT = 3'd3;
    localparam logic [2:0] IRQ_ADDR_ACK     = 3'd4;
    localparam logic [2:0] IRQ_ADDR_RAW     = 3'd5;

    typedef logic [IRQ_MAX-1:0]  irq_vec_t;
    typedef logic [IRQ_ID_W-1:0] irq_id_t;

    // CURRENT register word: valid flag on top, id in the low nibble
    function automatic logic [15:0] irq_cur_word(input logic valid, input irq_id_t id);
        logic [15:0] w;
        w                = '0;
        w[IRQ_CUR_VALID] = valid;
        w[IRQ_ID_W-1:0]  = id;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_enc
//  Description : Combinational 16-bit priority encoder, lowest index wins.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_prio_enc
    import irq_ctrl_pkg::*;
(
    input  logic [IRQ_MAX-1:0]  req,
    output logic [IRQ_ID_W-1:0] id,
    output logic                valid
);

    // Scan downwards so the last hit, the lowest index, is what remains
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = IRQ_MAX - 1; i >= 0; i--) begin
            if (req[i]) begin
                id    = IRQ_ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : irq_controller
//  Description : Avalon-MM interrupt controller: edge/level capture, masking
//                and lowest-index prioritisation of up to 16 sources.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               cpu_irq,
    output logic [3:0]         irq_id
);

    // Registers are kept 16 bits wide; bits at or above NUM_IRQ stay zero
    localparam logic [IRQ_MAX-1:0] c_valid_mask = IRQ_MAX'((33'h1 << NUM_IRQ) - 33'h1);

    irq_vec_t    w_irq_in;
    irq_vec_t    r_irq_q;
    irq_vec_t    r_irq_qq;
    irq_vec_t    r_pending;
    irq_vec_t    r_mask;
    irq_vec_t    r_edge;
    logic        r_cpu_irq;
    irq_id_t     r_irq_id;
    logic [15:0] r_readdata;

    logic        w_wr;
    irq_vec_t    w_rise;
    irq_vec_t    w_clr;
    irq_vec_t    w_edge_chg;
    irq_vec_t    w_pend_nxt;
    irq_vec_t    w_active;
    irq_id_t     w_ack_id;
    irq_id_t     w_enc_id;
    logic        w_enc_valid;
    logic [15:0] w_rd_mux;

    always_comb begin
        w_irq_in              = '0;
        w_irq_in[NUM_IRQ-1:0] = irq_in;
    end

    assign w_wr     = chipselect & ~write_n;
    assign w_rise   = r_irq_q & ~r_irq_qq;
    assign w_ack_id = writedata[IRQ_ID_W-1:0];
    assign w_active = r_pending & r_mask;

    // Software clears only ever touch edge-type bits
    always_comb begin
        w_clr      = '0;
        w_edge_chg = '0;
        if (w_wr && address == IRQ_ADDR_PENDING) begin
            w_clr = writedata & r_edge & c_valid_mask;
        end
        if (w_wr && address == IRQ_ADDR_ACK && ({28'd0, w_ack_id} < 32'(NUM_IRQ))) begin
            w_clr[w_ack_id] = r_edge[w_ack_id];
        end
        if (w_wr && address == IRQ_ADDR_EDGE) begin
            w_edge_chg = (writedata & c_valid_mask) ^ r_edge;
        end
    end

    // A rise in the same cycle as a clear wins, so no event is dropped
    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < IRQ_MAX; i++) begin
            if (w_edge_chg[i]) begin
                w_pend_nxt[i] = 1'b0;
            end else if (r_edge[i]) begin
                w_pend_nxt[i] = (r_pending[i] & ~w_clr[i]) | w_rise[i];
            end else begin
                w_pend_nxt[i] = r_irq_q[i];
            end
        end
    end

    irq_prio_enc u_prio_enc (
        .req   (w_active),
        .id    (w_enc_id),
        .valid (w_enc_valid)
    );

    always_comb begin
        w_rd_mux = '0;
        case (address)
            IRQ_ADDR_PENDING: w_rd_mux = r_pending;
            IRQ_ADDR_MASK:    w_rd_mux = r_mask;
            IRQ_ADDR_EDGE:    w_rd_mux = r_edge;
            IRQ_ADDR_CURRENT: w_rd_mux = irq_cur_word(r_cpu_irq, r_irq_id);
            IRQ_ADDR_RAW:     w_rd_mux = r_irq_q;
            default:          w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_q    <= '0;
            r_irq_qq   <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
            r_edge     <= '0;
            r_cpu_irq  <= 1'b0;
            r_irq_id   <= '0;
            r_readdata <= '0;
        end else begin
            r_irq_q    <= w_irq_in;
            r_irq_qq   <= r_irq_q;
            r_pending  <= w_pend_nxt & c_valid_mask;
            r_cpu_irq  <= w_enc_valid;
            r_irq_id   <= w_enc_id;
            r_readdata <= w_rd_mux;
            if (w_wr && address == IRQ_ADDR_MASK) begin
                r_mask <= writedata & c_valid_mask;
            end
            if (w_wr && address == IRQ_ADDR_EDGE) begin
                r_edge <= writedata & c_valid_mask;
            end
        end
    end

    assign readdata = r_readdata;
    assign cpu_irq  = r_cpu_irq;
    assign irq_id   = r_irq_id;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_controller
//  Description : Directed self-checking bench for irq_controller (NUM_IRQ=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_irq_controller;

    localparam int NUM_IRQ = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [2:0]         address;
    logic               chipselect;
    logic               write_n;
    logic [15:0]        writedata;
    logic [15:0]        readdata;
    logic [NUM_IRQ-1:0] irq_in;
    logic               cpu_irq;
    logic [3:0]         irq_id;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] rd;

    always #5 clk = ~clk;

    irq_controller #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .cpu_irq    (cpu_irq),
        .irq_id     (irq_id)
    );

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Inputs change on falling edges, so each posedge samples stable values
    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        irq_in     = '0;
        wait_cycles(3);
        reset = 1'b0;

        // Reset state: every address reads zero
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check_val($sformatf("reset_read_a%0d", a), rd, 16'h0000);
        end
        check_val("reset_cpu_irq", {15'd0, cpu_irq}, 16'h0000);
        check_val("reset_irq_id", {12'd0, irq_id}, 16'h0000);

        // Edge pulse on source 0
        bus_write(3'd2, 16'h0001);
        bus_write(3'd1, 16'h0001);
        @(negedge clk);
        irq_in[0] = 1'b1;
        @(negedge clk);
        irq_in[0] = 1'b0;
        check_val("pulse_cpu_irq_n", {15'd0, cpu_irq}, 16'h0000);
        @(negedge clk);
        check_val("pulse_cpu_irq_n1", {15'd0, cpu_irq}, 16'h0000);
        @(negedge clk);
        check_val("pulse_cpu_irq_n2", {15'd0, cpu_irq}, 16'h0001);
        wait_cycles(3);
        check_val("pulse_cpu_irq_hold", {15'd0, cpu_irq}, 16'h0001);
        bus_read(3'd0, rd);
        check_val("pulse_pending", rd, 16'h0001);
        bus_write(3'd4, 16'h0000);
        check_val("ack_cpu_irq_same", {15'd0, cpu_irq}, 16'h0001);
        @(negedge clk);
        check_val("ack_cpu_irq_drop", {15'd0, cpu_irq}, 16'h0000);
        bus_read(3'd0, rd);
        check_val("ack_pending", rd, 16'h0000);

        // Priority between level sources 5 and 2
        bus_write(3'd2, 16'h0000);
        bus_write(3'd1, 16'h00FF);
        @(negedge clk);
        irq_in[5] = 1'b1;
        irq_in[2] = 1'b1;
        wait_cycles(3);
        check_val("prio_irq_id", {12'd0, irq_id}, 16'h0002);
        check_val("prio_cpu_irq", {15'd0, cpu_irq}, 16'h0001);
        bus_read(3'd3, rd);
        check_val("prio_current", rd, 16'h8002);
        bus_read(3'd0, rd);
        check_val("prio_pending", rd, 16'h0024);
        @(negedge clk);
        irq_in[2] = 1'b0;
        wait_cycles(2);
        check_val("prio_drop_id_n1", {12'd0, irq_id}, 16'h0002);
        @(negedge clk);
        check_val("prio_drop_id_n2", {12'd0, irq_id}, 16'h0005);

        // Level source: W1C has no effect
        irq_in[5] = 1'b0;
        irq_in[4] = 1'b1;
        wait_cycles(3);
        bus_write(3'd0, 16'h0010);
        bus_read(3'd0, rd);
        check_val("level_w1c_ignored", rd, 16'h0010);
        irq_in[4] = 1'b0;
        wait_cycles(3);
        check_val("level_release_cpu_irq", {15'd0, cpu_irq}, 16'h0000);

        // Masked edge on source 3, then unmask
        bus_write(3'd1, 16'h0000);
        bus_write(3'd2, 16'h0008);
        @(negedge clk);
        irq_in[3] = 1'b1;
        @(negedge clk);
        irq_in[3] = 1'b0;
        wait_cycles(3);
        bus_read(3'd0, rd);
        check_val("mask_pending", rd, 16'h0008);
        check_val("mask_cpu_irq_off", {15'd0, cpu_irq}, 16'h0000);
        bus_write(3'd1, 16'h0008);
        check_val("unmask_cpu_irq_same", {15'd0, cpu_irq}, 16'h0000);
        @(negedge clk);
        check_val("unmask_cpu_irq", {15'd0, cpu_irq}, 16'h0001);
        check_val("unmask_irq_id", {12'd0, irq_id}, 16'h0003);
        bus_write(3'd0, 16'h0008);
        bus_read(3'd0, rd);
        check_val("w1c_edge_pending", rd, 16'h0000);

        // ACK in the same cycle the new rise reaches pending
        bus_write(3'd2, 16'h0002);
        bus_write(3'd1, 16'h0002);
        @(negedge clk);
        irq_in[1] = 1'b1;
        @(negedge clk);
        irq_in[1]  = 1'b0;
        address    = 3'd4;
        writedata  = 16'h0001;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        bus_read(3'd0, rd);
        check_val("set_clr_collision", rd, 16'h0002);
        bus_write(3'd4, 16'h0001);
        bus_read(3'd0, rd);
        check_val("ack_id1_clears", rd, 16'h0000);

        // Held-high edge source pends once only
        @(negedge clk);
        irq_in[1] = 1'b1;
        wait_cycles(3);
        bus_read(3'd0, rd);
        check_val("held_first_event", rd, 16'h0002);
        bus_write(3'd4, 16'h0001);
        wait_cycles(4);
        bus_read(3'd0, rd);
        check_val("held_no_repend", rd, 16'h0000);
        irq_in[1] = 1'b0;
        wait_cycles(2);

        // EDGE write clears pending bits whose type changes
        @(negedge clk);
        irq_in[1] = 1'b1;
        @(negedge clk);
        irq_in[1] = 1'b0;
        wait_cycles(3);
        bus_read(3'd0, rd);
        check_val("edge_chg_before", rd, 16'h0002);
        bus_write(3'd2, 16'h0000);
        bus_read(3'd0, rd);
        check_val("edge_chg_cleared", rd, 16'h0000);

        // Readback of unused bits and RAW input stage
        bus_write(3'd1, 16'hFFFF);
        bus_read(3'd1, rd);
        check_val("mask_unused_bits", rd, 16'h00FF);
        bus_write(3'd1, 16'h0000);
        irq_in = 8'hA5;
        wait_cycles(2);
        bus_read(3'd5, rd);
        check_val("raw_read", rd, 16'h00A5);
        bus_read(3'd4, rd);
        check_val("ack_reads_zero", rd, 16'h0000);
        bus_write(3'd6, 16'hFFFF);
        bus_read(3'd6, rd);
        check_val("addr6_zero", rd, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
